// File: rtl/register_rename.sv
// ---------------------------------------------------------------------------
// register_rename
//
// Purpose:
//   This is the rename stage that sits in front of the reorder buffer.
//   For each decoded instruction it does three things:
//     - maps the architectural sources to physical registers through the
//       speculative RAT;
//     - allocates a new physical destination from a bitmap free list;
//     - emits a ROB entry request one cycle later.
//   ROB commits update a retirement RAT (RRAT) and a committed-use bitmap.
//   The physical register that a commit supersedes goes back to the free
//   list. A flush rebuilds the RAT and the free list from the committed
//   state.
//
// Optional build macro:
//   RENAME_FREE_COUNT_EN - adds free_count_OUT (registered popcount of the
//   free bitmap). It also adds simulation checks on free-list bit
//   consistency.
//
// Ports:
//   CLK, RESET               clock, synchronous active-high reset
//   instr_valid_IN           decoded instruction present
//   regWrite_IN              instruction writes a register
//   readReg1_IN/readReg2_IN  architectural sources
//   writeArchReg_IN          architectural destination
//   instructionPC_IN         instruction PC
//   ROB_STALL_IN             ROB cannot accept an entry
//   commitRegWrite_IN        ROB commit of a register write
//   commitArchReg_IN         committed architectural destination
//   commitRegPointer_IN      committed physical destination
//   FLUSH_IN                 discard speculative state
//   newEntry_OUT             ROB entry valid (registered)
//   regWrite_OUT             forwarded regWrite (0 for r0 writes)
//   writeArchReg_OUT         forwarded destination
//   writeRegPointer_OUT      allocated physical destination
//   readPhys1_OUT/2_OUT      physical sources
//   instructionPC_OUT        forwarded PC
//   Rename_STALL             combinational: instruction not accepted
//   free_count_OUT           (RENAME_FREE_COUNT_EN only) free register count
// ---------------------------------------------------------------------------
module register_rename #(
   parameter  int unsigned NUM_ARCH_REGS = 32,
   parameter  int unsigned NUM_PHYS_REGS = 64,
   localparam int unsigned AW            = $clog2(NUM_ARCH_REGS),
   localparam int unsigned PW            = $clog2(NUM_PHYS_REGS),
   localparam int unsigned CW            = $clog2(NUM_PHYS_REGS + 1)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             instr_valid_IN,
   input  logic             regWrite_IN,
   input  logic [AW-1:0]    readReg1_IN,
   input  logic [AW-1:0]    readReg2_IN,
   input  logic [AW-1:0]    writeArchReg_IN,
   input  logic [31:0]      instructionPC_IN,
   input  logic             ROB_STALL_IN,
   input  logic             commitRegWrite_IN,
   input  logic [AW-1:0]    commitArchReg_IN,
   input  logic [PW-1:0]    commitRegPointer_IN,
   input  logic             FLUSH_IN,
   output logic             newEntry_OUT,
   output logic             regWrite_OUT,
   output logic [AW-1:0]    writeArchReg_OUT,
   output logic [PW-1:0]    writeRegPointer_OUT,
   output logic [PW-1:0]    readPhys1_OUT,
   output logic [PW-1:0]    readPhys2_OUT,
   output logic [31:0]      instructionPC_OUT,
   output logic             Rename_STALL
`ifdef RENAME_FREE_COUNT_EN
   ,
   output logic [CW-1:0]    free_count_OUT
`endif
);

   // Speculative and retirement maps, free list and committed-use bitmap
   logic [PW-1:0]            rat_q  [NUM_ARCH_REGS];
   logic [PW-1:0]            rat_d  [NUM_ARCH_REGS];
   logic [PW-1:0]            rrat_q [NUM_ARCH_REGS];
   logic [PW-1:0]            rrat_d [NUM_ARCH_REGS];
   logic [NUM_PHYS_REGS-1:0] free_q, free_d;
   logic [NUM_PHYS_REGS-1:0] used_q, used_d;

   // Registered output fields
   logic          new_entry_q, new_entry_d;
   logic          reg_write_q, reg_write_d;
   logic [AW-1:0] warch_q,     warch_d;
   logic [PW-1:0] wptr_q,      wptr_d;
   logic [PW-1:0] phys1_q,     phys1_d;
   logic [PW-1:0] phys2_q,     phys2_d;
   logic [31:0]   pc_q,        pc_d;

   logic          need_alloc;
   logic          free_empty;
   logic          accept;
   logic          do_commit;
   logic [PW-1:0] alloc_idx;
   logic [PW-1:0] commit_old;

   // r0 is hardwired and never renamed
   assign need_alloc   = regWrite_IN && (writeArchReg_IN != '0);
   assign free_empty   = ~|free_q;
   assign Rename_STALL = instr_valid_IN && (ROB_STALL_IN || (need_alloc && free_empty));
   assign accept       = instr_valid_IN && !Rename_STALL && !FLUSH_IN;
   assign do_commit    = commitRegWrite_IN && (commitArchReg_IN != '0);
   assign commit_old   = rrat_q[commitArchReg_IN];

   // Lowest-indexed free register. The loop scans downward so the lowest
   // set bit is the last one written.
   always_comb begin
      alloc_idx = '0;
      for (int i = int'(NUM_PHYS_REGS) - 1; i >= 0; i--) begin
         if (free_q[i]) alloc_idx = PW'(i);
      end
   end

   // Next-state logic. The commit is applied first. A flush then rebuilds
   // the speculative state from the post-commit view. Allocation works
   // from the pre-update free list, so a register freed this cycle can be
   // allocated only from the next cycle.
   always_comb begin
      rat_d       = rat_q;
      rrat_d      = rrat_q;
      free_d      = free_q;
      used_d      = used_q;
      new_entry_d = 1'b0;
      reg_write_d = reg_write_q;
      warch_d     = warch_q;
      wptr_d      = wptr_q;
      phys1_d     = phys1_q;
      phys2_d     = phys2_q;
      pc_d        = pc_q;

      if (do_commit) begin
         rrat_d[commitArchReg_IN]    = commitRegPointer_IN;
         free_d[commit_old]          = 1'b1;
         used_d[commit_old]          = 1'b0;
         used_d[commitRegPointer_IN] = 1'b1;
      end

      if (FLUSH_IN) begin
         rat_d  = rrat_d;
         free_d = ~used_d;
      end else if (accept) begin
         new_entry_d = 1'b1;
         reg_write_d = need_alloc;
         warch_d     = writeArchReg_IN;
         wptr_d      = need_alloc ? alloc_idx : '0;
         // Sources read the map before this instruction's own update
         phys1_d     = rat_q[readReg1_IN];
         phys2_d     = rat_q[readReg2_IN];
         pc_d        = instructionPC_IN;
         if (need_alloc) begin
            free_d[alloc_idx]      = 1'b0;
            rat_d[writeArchReg_IN] = alloc_idx;
         end
      end
   end

   // State registers. Reset gives an identity map, with the upper
   // physical registers free.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < int'(NUM_ARCH_REGS); i++) begin
            rat_q[i]  <= PW'(i);
            rrat_q[i] <= PW'(i);
         end
         for (int i = 0; i < int'(NUM_PHYS_REGS); i++) begin
            free_q[i] <= (i >= int'(NUM_ARCH_REGS));
            used_q[i] <= (i <  int'(NUM_ARCH_REGS));
         end
         new_entry_q <= 1'b0;
         reg_write_q <= 1'b0;
         warch_q     <= '0;
         wptr_q      <= '0;
         phys1_q     <= '0;
         phys2_q     <= '0;
         pc_q        <= '0;
      end else begin
         rat_q       <= rat_d;
         rrat_q      <= rrat_d;
         free_q      <= free_d;
         used_q      <= used_d;
         new_entry_q <= new_entry_d;
         reg_write_q <= reg_write_d;
         warch_q     <= warch_d;
         wptr_q      <= wptr_d;
         phys1_q     <= phys1_d;
         phys2_q     <= phys2_d;
         pc_q        <= pc_d;
      end
   end

   assign newEntry_OUT        = new_entry_q;
   assign regWrite_OUT        = reg_write_q;
   assign writeArchReg_OUT    = warch_q;
   assign writeRegPointer_OUT = wptr_q;
   assign readPhys1_OUT       = phys1_q;
   assign readPhys2_OUT       = phys2_q;
   assign instructionPC_OUT   = pc_q;

`ifdef RENAME_FREE_COUNT_EN
   logic [CW-1:0] free_count_q;

   // Tracks popcount of the free list as it will be after this edge
   always_ff @(posedge CLK) begin
      if (RESET) free_count_q <= CW'(NUM_PHYS_REGS - NUM_ARCH_REGS);
      else       free_count_q <= CW'($countones(free_d));
   end

   assign free_count_OUT = free_count_q;

   // Free-list consistency: never allocate a clear bit, never free a set bit
   always @(posedge CLK) begin
      if (!RESET) begin
         if (accept && need_alloc)
            assert (free_q[alloc_idx])
            else $error("register_rename: allocating non-free phys %0d", alloc_idx);
         if (do_commit)
            assert (!free_q[commit_old])
            else $error("register_rename: freeing already-free phys %0d", commit_old);
      end
   end
`endif

endmodule

// File: tb/tb_register_rename.sv
// ---------------------------------------------------------------------------
// tb_register_rename
// Directed stimulus with hand-computed expected ROB entries. Each expected
// entry is queued when the stimulus issues its instruction. A monitor
// compares the queue against every newEntry_OUT cycle.
// ---------------------------------------------------------------------------
module tb_register_rename;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        instr_valid_IN;
   logic        regWrite_IN;
   logic [4:0]  readReg1_IN;
   logic [4:0]  readReg2_IN;
   logic [4:0]  writeArchReg_IN;
   logic [31:0] instructionPC_IN;
   logic        ROB_STALL_IN;
   logic        commitRegWrite_IN;
   logic [4:0]  commitArchReg_IN;
   logic [5:0]  commitRegPointer_IN;
   logic        FLUSH_IN;
   logic        newEntry_OUT;
   logic        regWrite_OUT;
   logic [4:0]  writeArchReg_OUT;
   logic [5:0]  writeRegPointer_OUT;
   logic [5:0]  readPhys1_OUT;
   logic [5:0]  readPhys2_OUT;
   logic [31:0] instructionPC_OUT;
   logic        Rename_STALL;
`ifdef RENAME_FREE_COUNT_EN
   logic [6:0]  free_count_OUT;
`endif

   register_rename dut (
      .CLK                 (CLK),
      .RESET               (RESET),
      .instr_valid_IN      (instr_valid_IN),
      .regWrite_IN         (regWrite_IN),
      .readReg1_IN         (readReg1_IN),
      .readReg2_IN         (readReg2_IN),
      .writeArchReg_IN     (writeArchReg_IN),
      .instructionPC_IN    (instructionPC_IN),
      .ROB_STALL_IN        (ROB_STALL_IN),
      .commitRegWrite_IN   (commitRegWrite_IN),
      .commitArchReg_IN    (commitArchReg_IN),
      .commitRegPointer_IN (commitRegPointer_IN),
      .FLUSH_IN            (FLUSH_IN),
      .newEntry_OUT        (newEntry_OUT),
      .regWrite_OUT        (regWrite_OUT),
      .writeArchReg_OUT    (writeArchReg_OUT),
      .writeRegPointer_OUT (writeRegPointer_OUT),
      .readPhys1_OUT       (readPhys1_OUT),
      .readPhys2_OUT       (readPhys2_OUT),
      .instructionPC_OUT   (instructionPC_OUT),
      .Rename_STALL        (Rename_STALL)
`ifdef RENAME_FREE_COUNT_EN
      ,
      .free_count_OUT      (free_count_OUT)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        rw;
      logic [4:0]  warch;
      logic [5:0]  wptr;
      logic [5:0]  p1;
      logic [5:0]  p2;
      logic [31:0] pc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   passed = 0;
   int   total  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
   endtask

   function automatic exp_t mk(input logic rw, input logic [4:0] wa, input logic [5:0] wp,
                               input logic [5:0] p1, input logic [5:0] p2, input logic [31:0] pc);
      exp_t e;
      e.rw = rw; e.warch = wa; e.wptr = wp; e.p1 = p1; e.p2 = p2; e.pc = pc;
      return e;
   endfunction

   // Monitor: every presented ROB entry must match the head of the queue
   always @(negedge CLK) begin
      if (newEntry_OUT === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_entry: got entry pc=0x%0h wptr=%0d, expected none (t=%0t)",
                     instructionPC_OUT, writeRegPointer_OUT, $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("entry_pc",    instructionPC_OUT,         mon_e.pc);
            check("entry_rw",    32'(regWrite_OUT),         32'(mon_e.rw));
            check("entry_warch", 32'(writeArchReg_OUT),     32'(mon_e.warch));
            check("entry_wptr",  32'(writeRegPointer_OUT),  32'(mon_e.wptr));
            check("entry_phys1", 32'(readPhys1_OUT),        32'(mon_e.p1));
            check("entry_phys2", 32'(readPhys2_OUT),        32'(mon_e.p2));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_instr();
      instr_valid_IN   = 1'b0;
      regWrite_IN      = 1'b0;
      readReg1_IN      = '0;
      readReg2_IN      = '0;
      writeArchReg_IN  = '0;
      instructionPC_IN = '0;
   endtask

   task automatic drive(input logic rw, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [31:0] pc);
      instr_valid_IN   = 1'b1;
      regWrite_IN      = rw;
      writeArchReg_IN  = d;
      readReg1_IN      = s1;
      readReg2_IN      = s2;
      instructionPC_IN = pc;
   endtask

   task automatic commit(input logic en, input logic [4:0] a, input logic [5:0] p);
      commitRegWrite_IN   = en;
      commitArchReg_IN    = a;
      commitRegPointer_IN = p;
   endtask

   // Issue an instruction that must be accepted, and queue its expected entry
   task automatic send(input logic rw, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] pc, input exp_t e);
      drive(rw, d, s1, s2, pc);
      #1 check("stall_on_send", 32'(Rename_STALL), 32'd0);
      tick();
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      idle_instr();
      commit(1'b0, '0, '0);
      FLUSH_IN     = 1'b0;
      ROB_STALL_IN = 1'b0;
      RESET        = 1'b1;
      tick();
      tick();
      RESET = 1'b0;
   endtask

   initial begin
      // Scenario 1: reset state, basic renaming, r0 write
      do_reset();
      #1;
      check("reset_newEntry", 32'(newEntry_OUT),        32'd0);
      check("reset_regWrite", 32'(regWrite_OUT),        32'd0);
      check("reset_wptr",     32'(writeRegPointer_OUT), 32'd0);
      check("reset_phys1",    32'(readPhys1_OUT),       32'd0);
      check("reset_pc",       instructionPC_OUT,        32'd0);
      send(1, 5, 5, 3, 32'h100, mk(1, 5, 32, 5, 3, 32'h100));
      send(1, 6, 5, 6, 32'h104, mk(1, 6, 33, 32, 6, 32'h104));
      send(1, 0, 0, 5, 32'h108, mk(0, 0, 0, 0, 32, 32'h108));
      send(1, 7, 7, 0, 32'h10C, mk(1, 7, 34, 7, 0, 32'h10C));
      idle_instr();
      tick();
      #1;
      check("hold_newEntry", 32'(newEntry_OUT),        32'd0);
      check("hold_wptr",     32'(writeRegPointer_OUT), 32'd34);
      check("hold_pc",       instructionPC_OUT,        32'h10C);
      check("hold_phys1",    32'(readPhys1_OUT),       32'd7);
      tick();

      // Scenario 2: exhaust the free list, then free a register via commit
      do_reset();
      for (int i = 0; i < 32; i++) begin
         int d;
         d = (i % 31) + 1;
         send(1, 5'(d), 0, 0, 32'(i * 4), mk(1, 5'(d), 6'(32 + i), 0, 0, 32'(i * 4)));
      end
      drive(1, 5, 5, 1, 32'h200);
      commit(1'b1, 5, 32);
      #1 check("stall_free_empty", 32'(Rename_STALL), 32'd1);
      tick();
      commit(1'b0, '0, '0);
      #1;
      check("no_entry_when_stalled", 32'(newEntry_OUT), 32'd0);
      check("stall_released",        32'(Rename_STALL), 32'd0);
      tick();
      exp_q.push_back(mk(1, 5, 5, 36, 63, 32'h200));
      idle_instr();
      tick();

      // Scenario 3: commit + flush restores RAT/free list from committed state
      do_reset();
      send(1, 1, 0, 0, 32'h400, mk(1, 1, 32, 0, 0, 32'h400));
      send(1, 2, 0, 0, 32'h404, mk(1, 2, 33, 0, 0, 32'h404));
      send(1, 3, 0, 0, 32'h408, mk(1, 3, 34, 0, 0, 32'h408));
      idle_instr();
      commit(1'b1, 1, 32);
      tick();
      commit(1'b1, 2, 33);
      FLUSH_IN = 1'b1;
      drive(1, 9, 1, 1, 32'h40C);
      tick();
      commit(1'b0, '0, '0);
      idle_instr();
      #1 check("no_entry_on_flush", 32'(newEntry_OUT), 32'd0);
      tick();
      FLUSH_IN = 1'b0;
      send(1, 4, 1, 2, 32'h410, mk(1, 4, 1, 32, 33, 32'h410));
      send(1, 5, 3, 4, 32'h414, mk(1, 5, 2, 3, 1, 32'h414));
      send(1, 6, 0, 0, 32'h418, mk(1, 6, 34, 0, 0, 32'h418));
      idle_instr();
      tick();

      // Scenario 4: ROB back-pressure holds the instruction without allocating
      do_reset();
      ROB_STALL_IN = 1'b1;
      #1 check("stall_needs_valid", 32'(Rename_STALL), 32'd0);
      drive(1, 8, 8, 2, 32'h300);
      #1 check("stall_rob", 32'(Rename_STALL), 32'd1);
      tick();
      check("stall_rob_hold",     32'(Rename_STALL), 32'd1);
      check("no_entry_rob_stall", 32'(newEntry_OUT), 32'd0);
      tick();
      ROB_STALL_IN = 1'b0;
      send(1, 8, 8, 2, 32'h300, mk(1, 8, 32, 8, 2, 32'h300));
      send(1, 9, 8, 9, 32'h304, mk(1, 9, 33, 32, 9, 32'h304));
      idle_instr();
      tick();
      tick();
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
